uart_tx_arb: RTL

UART_TX_ARB -- requirements
Module: uart_tx_arb

---
 rtl/uart_pkg.sv | 17 +
 rtl/rr_arbiter.sv | 42 ++++
 rtl/uart_tx_arb.sv | 131 +++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM encodings and
// the default requester count.
package uart_pkg;

    localparam int N_REQ_DEFAULT = 4;

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_LAUNCH    = 2'd1;
    localparam logic [1:0] ST_WAIT_BUSY = 2'd2;
    localparam logic [1:0] ST_WAIT_DONE = 2'd3;

    // True when the arbiter owns a byte, i.e. in every state except IDLE.
    function automatic logic state_is_busy(input logic [1:0] st);
        return (st != ST_IDLE);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker. The search starts one past the last
// grant and wraps, so the most recently served requester has lowest priority.
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int IDW   = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IDW-1:0]   last_i,
    output logic [N_REQ-1:0] grant_o,
    output logic [IDW-1:0]   idx_o
);

    logic           found_s;
    logic [IDW:0]   sum_s;
    logic [IDW-1:0] cand_s;

    // Walk the requesters in rotated priority order and keep the first hit.
    always_comb begin
        grant_o = {N_REQ{1'b0}};
        idx_o   = {IDW{1'b0}};
        found_s = 1'b0;
        sum_s   = {(IDW+1){1'b0}};
        cand_s  = {IDW{1'b0}};
        for (int k = 1; k <= N_REQ; k++) begin
            sum_s = {1'b0, last_i} + (IDW+1)'(k);
            if (sum_s >= (IDW+1)'(N_REQ)) begin
                sum_s = sum_s - (IDW+1)'(N_REQ);
            end else begin
                sum_s = sum_s;
            end
            cand_s = sum_s[IDW-1:0];
            if (!found_s && req_i[cand_s]) begin
                found_s         = 1'b1;
                grant_o[cand_s] = 1'b1;
                idx_o           = cand_s;
            end else begin
                found_s = found_s;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arb.sv
// Arbitrates N_REQ byte sources onto a single UART transmitter. One byte is
// accepted in IDLE, launched with a one-cycle start pulse, and the arbiter
// then follows the transmitter's busy flag until the frame is finished.
module uart_tx_arb
    import uart_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEFAULT,
    parameter int IDW   = $clog2(N_REQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [8*N_REQ-1:0] req_data,
    output logic [N_REQ-1:0]   req_ready,
    output logic               uart_tx_en,
    output logic [7:0]         uart_tx_data,
    input  logic               uart_tx_busy,
    output logic [IDW-1:0]     grant_id,
    output logic               arb_busy
);

    logic [1:0]       state_q, state_d;
    logic             en_q, en_d;
    logic [7:0]       data_q, data_d;
    logic [IDW-1:0]   gid_q, gid_d;
    logic [IDW-1:0]   last_q, last_d;
    logic             busy_q, busy_d;
    logic [N_REQ-1:0] grant_s;
    logic [IDW-1:0]   win_s;
    logic [N_REQ-1:0] ready_s;
    logic [7:0]       byte_s;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .IDW   (IDW)
    ) u_rr (
        .req_i   (req_valid),
        .last_i  (last_q),
        .grant_o (grant_s),
        .idx_o   (win_s)
    );

    // Select the winning requester's byte with a one-hot AND-OR mux.
    always_comb begin
        byte_s = 8'h00;
        for (int i = 0; i < N_REQ; i++) begin
            byte_s = byte_s | (req_data[8*i +: 8] & {8{grant_s[i]}});
        end
    end

    // Next-state logic. Acceptance also waits for an idle transmitter so a
    // start pulse can never land on a frame still in progress (e.g. after a
    // reset that abandoned a byte mid-frame).
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        gid_d   = gid_q;
        last_d  = last_q;
        en_d    = 1'b0;
        ready_s = {N_REQ{1'b0}};
        case (state_q)
            ST_IDLE: begin
                if ((|req_valid) && !uart_tx_busy) begin
                    ready_s = grant_s;
                    data_d  = byte_s;
                    gid_d   = win_s;
                    last_d  = win_s;
                    en_d    = 1'b1;
                    state_d = ST_LAUNCH;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LAUNCH: begin
                state_d = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                if (uart_tx_busy) begin
                    state_d = ST_WAIT_DONE;
                end else begin
                    state_d = ST_WAIT_BUSY;
                end
            end
            ST_WAIT_DONE: begin
                if (!uart_tx_busy) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_WAIT_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = state_is_busy(state_d);
    end

    // The accept strobe is suppressed while reset is held.
    always_comb begin
        if (rst) begin
            req_ready = {N_REQ{1'b0}};
        end else begin
            req_ready = ready_s;
        end
    end

    // State and output registers; requester 0 has top priority after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            en_q    <= 1'b0;
            data_q  <= 8'h00;
            gid_q   <= {IDW{1'b0}};
            last_q  <= IDW'(N_REQ-1);
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            en_q    <= en_d;
            data_q  <= data_d;
            gid_q   <= gid_d;
            last_q  <= last_d;
            busy_q  <= busy_d;
        end
    end

    assign uart_tx_en   = en_q;
    assign uart_tx_data = data_q;
    assign grant_id     = gid_q;
    assign arb_busy     = busy_q;

endmodule
